// File: rtl/sdram_cmd_responder.sv
`default_nettype none
// ============================================================================
// sdram_cmd_responder: BRAM-backed stand-in for the SDRAM controller command
// port, reproducing init, row-activate, refresh and read-latency timing.
// Revision: 1.0
// ============================================================================
module sdram_cmd_responder #(
  parameter int AddrWidth       = 23,
  parameter int MemAddrWidth    = 12,
  parameter int ColWidth        = 8,
  parameter int InitCycles      = 16,
  parameter int ActivateCycles  = 3,
  parameter int ReadLatency     = 3,
  parameter int RefreshInterval = 96,
  parameter int RefreshCycles   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 cmdReady,
  input  logic                 cmdTrigger,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic                 cmdWrite,
  input  logic [15:0]          cmdWriteData,
  output logic [15:0]          cmdReadData,
  output logic                 cmdReadDataValid
);

  localparam int TagWidth   = AddrWidth - ColWidth;
  localparam int StallMax   = (InitCycles > ActivateCycles) ?
                              ((InitCycles > RefreshCycles) ? InitCycles : RefreshCycles) :
                              ((ActivateCycles > RefreshCycles) ? ActivateCycles : RefreshCycles);
  localparam int StallWidth = $clog2(StallMax + 1);
  localparam int RefWidth   = $clog2(RefreshInterval);
  localparam int MemDepth   = 2 ** MemAddrWidth;

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_ACTIVATE = 2'd2;
  localparam logic [1:0] ST_REFRESH  = 2'd3;

  logic [1:0]            state;
  logic [StallWidth-1:0] stall_cnt;
  logic [RefWidth-1:0]   ref_cnt;
  logic                  refresh_due;
  logic                  open_valid;
  logic [TagWidth-1:0]   open_tag;

  logic                  held_write;
  logic [AddrWidth-1:0]  held_addr;
  logic [15:0]           held_data;

  logic [15:0]           mem [0:MemDepth-1];
  logic                  rd_valid_pipe [0:ReadLatency-1];
  logic [15:0]           rd_data_pipe  [0:ReadLatency-1];

  logic                  accept;
  logic                  row_hit;
  logic                  act_done;
  logic                  exec_en;
  logic                  exec_write;
  logic [MemAddrWidth-1:0] exec_addr;
  logic [15:0]           exec_data;

  assign cmdReady = (state == ST_READY) && !refresh_due;
  assign accept   = cmdReady && cmdTrigger;
  assign row_hit  = open_valid && (cmdAddr[AddrWidth-1:ColWidth] == open_tag);
  assign act_done = (state == ST_ACTIVATE) &&
                    (stall_cnt == StallWidth'(ActivateCycles - 1));

  // Single execute slot: either a row-hit command straight from the port or
  // the command held across an activate; the two are mutually exclusive.
  always_comb begin
    exec_en    = 1'b0;
    exec_write = 1'b0;
    exec_addr  = cmdAddr[MemAddrWidth-1:0];
    exec_data  = cmdWriteData;
    if (accept && row_hit) begin
      exec_en    = 1'b1;
      exec_write = cmdWrite;
    end else if (act_done) begin
      exec_en    = 1'b1;
      exec_write = held_write;
      exec_addr  = held_addr[MemAddrWidth-1:0];
      exec_data  = held_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      stall_cnt   <= '0;
      ref_cnt     <= '0;
      refresh_due <= 1'b0;
      open_valid  <= 1'b0;
      open_tag    <= '0;
      held_write  <= 1'b0;
      held_addr   <= '0;
      held_data   <= '0;
    end else begin
      if (state != ST_INIT) begin
        if (ref_cnt == RefWidth'(RefreshInterval - 1)) begin
          ref_cnt     <= '0;
          refresh_due <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + RefWidth'(1);
        end
      end

      case (state)
        ST_INIT: begin
          if (stall_cnt == StallWidth'(InitCycles - 1)) begin
            stall_cnt <= '0;
            state     <= ST_READY;
          end else begin
            stall_cnt <= stall_cnt + StallWidth'(1);
          end
        end
        ST_READY: begin
          if (refresh_due) begin
            refresh_due <= 1'b0;
            open_valid  <= 1'b0;
            stall_cnt   <= '0;
            state       <= ST_REFRESH;
          end else if (accept && !row_hit) begin
            held_write <= cmdWrite;
            held_addr  <= cmdAddr;
            held_data  <= cmdWriteData;
            stall_cnt  <= '0;
            state      <= ST_ACTIVATE;
          end
        end
        ST_ACTIVATE: begin
          if (act_done) begin
            open_valid <= 1'b1;
            open_tag   <= held_addr[AddrWidth-1:ColWidth];
            stall_cnt  <= '0;
            state      <= ST_READY;
          end else begin
            stall_cnt <= stall_cnt + StallWidth'(1);
          end
        end
        ST_REFRESH: begin
          if (stall_cnt == StallWidth'(RefreshCycles - 1)) begin
            stall_cnt <= '0;
            state     <= ST_READY;
          end else begin
            stall_cnt <= stall_cnt + StallWidth'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (exec_en && exec_write) begin
      mem[exec_addr] <= exec_data;
    end
  end

  // Data path carries no reset so the memory read maps onto block RAM.
  always_ff @(posedge clk) begin
    if (exec_en && !exec_write) begin
      rd_data_pipe[0] <= mem[exec_addr];
    end
    for (int i = 1; i < ReadLatency; i++) begin
      rd_data_pipe[i] <= rd_data_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ReadLatency; i++) begin
        rd_valid_pipe[i] <= 1'b0;
      end
      cmdReadDataValid <= 1'b0;
      cmdReadData      <= '0;
    end else begin
      rd_valid_pipe[0] <= exec_en && !exec_write;
      for (int i = 1; i < ReadLatency; i++) begin
        rd_valid_pipe[i] <= rd_valid_pipe[i-1];
      end
      cmdReadDataValid <= rd_valid_pipe[ReadLatency-1];
      if (rd_valid_pipe[ReadLatency-1]) begin
        cmdReadData <= rd_data_pipe[ReadLatency-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_responder.sv
`default_nettype none
// ============================================================================
// tb_sdram_cmd_responder: randomized scoreboard bench with a cycle-level
// behavioural model of row/refresh timing and a word-array memory model.
// Revision: 1.0
// ============================================================================
module tb_sdram_cmd_responder;

  localparam int IC  = 16;
  localparam int AC  = 3;
  localparam int RL  = 3;
  localparam int RI  = 96;
  localparam int RC  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdReady;
  logic        cmdTrigger = 1'b0;
  logic [22:0] cmdAddr = '0;
  logic        cmdWrite = 1'b0;
  logic [15:0] cmdWriteData = '0;
  logic [15:0] cmdReadData;
  logic        cmdReadDataValid;

  sdram_cmd_responder dut (
    .clk              (clk),
    .rst              (rst),
    .cmdReady         (cmdReady),
    .cmdTrigger       (cmdTrigger),
    .cmdAddr          (cmdAddr),
    .cmdWrite         (cmdWrite),
    .cmdWriteData     (cmdWriteData),
    .cmdReadData      (cmdReadData),
    .cmdReadDataValid (cmdReadDataValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    bit          known;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mmem   [int];
  bit          mknown [int];
  int          checks   = 0;
  int          failures = 0;
  int          n_valid  = 0;
  int          e0, rdy_edge, last_acc;
  bit          open_valid;
  logic [14:0] open_tag;
  int          w;

  task automatic chk(input string name, input bit ok, input longint act, input longint expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, expv, cyc);
    end
  endtask

  // Refresh requests are raised every RI cycles after the first ready edge;
  // each one closes the open row before any later-accepted command.
  function automatic bit has_due(input int lo, input int hi);
    for (int t = rdy_edge + RI; t < hi; t += RI) begin
      if (t >= lo) return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cmdReadDataValid) begin
      n_valid++;
      if (q.size() == 0) begin
        chk("unexpected_valid", 1'b0, 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("read_latency", cyc == e.t, cyc, e.t);
        if (e.known) chk("read_data", cmdReadData === e.data, cmdReadData, e.data);
      end
    end
  end

  task automatic issue(input bit wr, input logic [22:0] a, input logic [15:0] d,
                       output int waited);
    int          acc, ex, idx;
    logic [14:0] tag;
    bit          hit;
    exp_t        e;
    waited = 0;
    @(negedge clk);
    cmdTrigger = 1'b1; cmdWrite = wr; cmdAddr = a; cmdWriteData = d;
    while (!cmdReady && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmdReady) begin
      chk("accept_timeout", 1'b0, waited, 300);
      cmdTrigger = 1'b0;
      return;
    end
    acc = cyc + 1;
    tag = a[22:8];
    idx = int'(a[11:0]);
    if (has_due(last_acc, acc)) open_valid = 1'b0;
    hit = open_valid && (open_tag == tag);
    ex  = hit ? acc : acc + AC;
    open_valid = 1'b1; open_tag = tag; last_acc = acc;
    if (wr) begin
      mmem[idx] = d; mknown[idx] = 1'b1;
    end else begin
      e.t     = ex + RL;
      e.known = mknown.exists(idx);
      e.data  = e.known ? mmem[idx] : 16'h0;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cmdTrigger = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      cmdTrigger = 1'b0;
      k++;
    end
    chk("drain_all_reads", q.size() == 0, q.size(), 0);
  endtask

  // Caller is positioned at a negedge; rst is held for two edges.
  task automatic do_reset();
    rst = 1'b1; cmdTrigger = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = cyc; rdy_edge = e0 + IC; last_acc = rdy_edge; open_valid = 1'b0;
    chk("reset_ready",      cmdReady == 1'b0, cmdReady, 0);
    chk("reset_valid",      cmdReadDataValid == 1'b0, cmdReadDataValid, 0);
    chk("reset_read_data",  cmdReadData == 16'h0, cmdReadData, 0);
    for (int k = 1; k <= IC; k++) begin
      @(negedge clk);
      chk("init_ready", cmdReady == (k == IC), cmdReady, (k == IC));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int d, first_t, v_before;
    @(negedge clk);
    do_reset();

    // write then read same word: miss stall, then immediate hit
    issue(1'b1, 23'h000010, 16'hA5A5, w);
    for (int i = 0; i < AC; i++) begin
      @(negedge clk);
      cmdTrigger = 1'b0;
      chk("activate_stall", cmdReady == 1'b0, cmdReady, 0);
    end
    issue(1'b0, 23'h000010, 16'h0, w);
    chk("hit_accept_immediate", w == 0, w, 0);
    drain();

    // two row misses back to back, then read both back
    issue(1'b1, 23'h000100, 16'h0100, w);
    issue(1'b1, 23'h000200, 16'h0200, w);
    chk("second_miss_stall", w == AC, w, AC);
    issue(1'b0, 23'h000100, 16'h0, w);
    issue(1'b0, 23'h000200, 16'h0, w);
    drain();

    // aliasing beyond BRAM depth
    issue(1'b1, 23'h001005, 16'h1234, w);
    issue(1'b0, 23'h000005, 16'h0, w);
    drain();

    // idle refresh window: one due cycle plus RC refresh cycles
    idle(2);
    d = rdy_edge + RI * ((cyc + 4 - rdy_edge) / RI + 1);
    while (cyc < d - 1) @(negedge clk);
    chk("ready_before_refresh", cmdReady == 1'b1, cmdReady, 1);
    for (int k = 0; k <= RC + 1; k++) begin
      @(negedge clk);
      chk("refresh_stall", cmdReady == (k == RC + 1), cmdReady, (k == RC + 1));
    end

    // stream of row-0 reads with trigger held across refreshes
    for (int i = 0; i < 32; i++) issue(1'b1, 23'(i), 16'($urandom), w);
    v_before = n_valid;
    for (int i = 0; i < 300; i++) issue(1'b0, 23'($urandom_range(0, 31)), 16'h0, w);
    drain();
    chk("stream_pulse_count", n_valid - v_before == 300, n_valid - v_before, 300);

    // randomized mix over several tags, including an aliasing tag
    for (int i = 0; i < 200; i++) begin
      logic [14:0] tags [5];
      logic [14:0] tg;
      tags[0] = 15'h0000; tags[1] = 15'h0001; tags[2] = 15'h0002;
      tags[3] = 15'h0010; tags[4] = 15'h7FFF;
      tg = tags[$urandom_range(0, 4)];
      issue(1'($urandom_range(0, 1)), {tg, 8'($urandom_range(0, 7))}, 16'($urandom), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // reset while three reads are in flight: no pulses survive
    @(negedge clk);
    cmdTrigger = 1'b0;
    do_reset();
    issue(1'b0, 23'h000010, 16'h0, w);
    issue(1'b0, 23'h000011, 16'h0, w);
    issue(1'b0, 23'h000012, 16'h0, w);
    first_t = q[0].t;
    @(negedge clk);
    while (cyc < first_t - 1) @(negedge clk);
    v_before = n_valid;
    do_reset();
    idle(10);
    chk("no_valid_after_reset", n_valid == v_before, n_valid - v_before, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
